// File: rtl/imem_fetch_if.sv
// Loader and fetch signal bundle between the PC/fetch stage and the instruction memory.
// The fetch stage uses the master modport and the memory uses the slave modport.
interface imem_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              ld_start;
    logic              ld_en;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_done;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;

    modport master (
        output ld_start, ld_en, ld_data, rd_en, rd_addr, stall, flush,
        input  ld_ptr, ld_done, instr, instr_addr, instr_valid
    );

    modport slave (
        input  ld_start, ld_en, ld_data, rd_en, rd_addr, stall, flush,
        output ld_ptr, ld_done, instr, instr_addr, instr_valid
    );
endinterface

// File: rtl/imem_fetch.sv
// Parametrised instruction memory with a registered fetch port and a sequential program loader.
// Fetch has one cycle of latency, and a same-cycle load to the fetched address is forwarded write-first.
module imem_fetch #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic        clk,
    input  logic        rst,
    imem_fetch_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_wr;

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              instr_valid_q, instr_valid_d;

    // Loader next state. ld_start outranks ld_en and suppresses the write.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        ld_wr     = bus.ld_en && !bus.ld_start;
        ld_ptr_d  = ld_ptr_q;
        ld_done_d = 1'b0;
        if (bus.ld_start) begin
            ld_ptr_d = '0;
        end else if (bus.ld_en) begin
            ld_ptr_d  = ld_ptr_q + ADDR_W'(1);
            ld_done_d = (ld_ptr_q == ADDR_W'(DEPTH - 1));
        end
    end

    // A write landing this cycle at the fetched address is forwarded to the fetch.
    always_comb begin
        if (ld_wr && (bus.rd_addr == ld_ptr_q)) begin
            rd_word = bus.ld_data;
        end else begin
            rd_word = mem_q[bus.rd_addr];
        end
    end

    always_comb begin
        instr_d       = NOP_WORD;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = 1'b0;
        if (bus.flush) begin
            instr_d = NOP_WORD;
        end else if (bus.stall) begin
            instr_d       = instr_q;
            instr_valid_d = instr_valid_q;
        end else if (bus.rd_en) begin
            instr_d       = rd_word;
            instr_addr_d  = bus.rd_addr;
            instr_valid_d = 1'b1;
        end
    end

    // NOTE: the storage array has no reset, so a program loaded before rst survives it.
    always_ff @(posedge clk) begin
        if (!rst && ld_wr) begin
            mem_q[ld_ptr_q] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
        if (rst) begin
            ld_ptr_q      <= '0;
            ld_done_q     <= 1'b0;
            instr_q       <= NOP_WORD;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            ld_ptr_q      <= ld_ptr_d;
            ld_done_q     <= ld_done_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.ld_ptr      = ld_ptr_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.instr_valid = instr_valid_q;
endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios followed by random traffic,
// all compared against a word-array reference model.
module tb_imem_fetch;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam logic [DATA_W-1:0] NOP = 16'h0000;

    logic clk = 1'b0;
    logic rst;

    imem_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_ptr;
    bit                m_done;
    logic [DATA_W-1:0] m_instr;
    int                m_addr;
    bit                m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_step();
        bit wr;
        if (rst) begin
            m_ptr   = 0;
            m_done  = 0;
            m_instr = NOP;
            m_addr  = 0;
            m_valid = 0;
            return;
        end
        wr     = bus.ld_en && !bus.ld_start;
        m_done = wr && (m_ptr == DEPTH - 1);
        if (wr) m_mem[m_ptr] = bus.ld_data;
        if (bus.ld_start)  m_ptr = 0;
        else if (wr)       m_ptr = (m_ptr + 1) % DEPTH;
        if (bus.flush) begin
            m_instr = NOP;
            m_valid = 0;
        end else if (bus.stall) begin
            // hold everything
        end else if (bus.rd_en) begin
            m_instr = m_mem[bus.rd_addr];
            m_addr  = int'(bus.rd_addr);
            m_valid = 1;
        end else begin
            m_instr = NOP;
            m_valid = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("ld_ptr",      32'(bus.ld_ptr),      32'(m_ptr));
        check("ld_done",     32'(bus.ld_done),     32'(m_done));
        check("instr",       32'(bus.instr),       32'(m_instr));
        check("instr_addr",  32'(bus.instr_addr),  32'(m_addr));
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_en    = 1'b0;
        bus.ld_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic load_words(input int count);
        bus.ld_en = 1'b1;
        for (int i = 0; i < count; i++) begin
            bus.ld_data = DATA_W'(16'h1000 + i);
            tick();
        end
        bus.ld_en = 1'b0;
    endtask

    initial begin
        int done_cnt;
        idle_inputs();
        m_ptr = 0; m_done = 0; m_instr = NOP; m_addr = 0; m_valid = 0;

        // Reset with a fetch request pending.
        rst = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd9;
        tick();
        tick();
        check("rst_instr", 32'(bus.instr), 32'(NOP));
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        idle_inputs();

        // Full program load.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_en = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.ld_data = DATA_W'(16'h1000 + i);
            tick();
            if (bus.ld_done) done_cnt++;
        end
        bus.ld_en = 1'b0;
        check("ld_done_pulses", 32'(done_cnt), 32'd1);
        check("ld_ptr_wrap", 32'(bus.ld_ptr), 32'd0);

        // Back-to-back fetch of every address.
        bus.rd_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = ADDR_W'(a);
            tick();
            check("seq_fetch", 32'(bus.instr), 32'h1000 + 32'(a));
        end

        // Stall holds the addr-3 word while rd_addr moves to 7.
        bus.rd_addr = 4'd3;
        tick();
        bus.stall = 1'b1;
        bus.rd_addr = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", 32'(bus.instr), 32'h1003);
            check("stall_addr", 32'(bus.instr_addr), 32'd3);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_instr", 32'(bus.instr), 32'h1007);

        // Flush beats stall.
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        check("flush_instr", 32'(bus.instr), 32'(NOP));
        check("flush_valid", 32'(bus.instr_valid), 32'd0);
        idle_inputs();

        // Write-first bypass at pointer 5.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_words(5);
        check("ptr_at_5", 32'(bus.ld_ptr), 32'd5);
        bus.ld_en = 1'b1;
        bus.ld_data = 16'hBEEF;
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd5;
        tick();
        check("bypass_instr", 32'(bus.instr), 32'hBEEF);
        idle_inputs();

        // Reset in the middle of a load keeps written words.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_words(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ptr", 32'(bus.ld_ptr), 32'd0);
        bus.rd_en = 1'b1;
        bus.rd_addr = 4'd4;
        tick();
        check("midrst_fetch", 32'(bus.instr), 32'h1004);
        idle_inputs();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 49) == 0);
            bus.ld_start = ($urandom_range(0, 15) == 0);
            bus.ld_en    = $urandom_range(0, 1) == 1;
            bus.ld_data  = DATA_W'($urandom);
            bus.rd_en    = ($urandom_range(0, 3) != 0);
            bus.rd_addr  = ADDR_W'($urandom);
            bus.stall    = ($urandom_range(0, 4) == 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a registered fetch port and an auto-incrementing program loader. Successor to the fixed 16-bit instruction memory: width and depth are parameters, and it adds stall/flush handshakes, a valid flag and sequential program loading. It sits between the PC/fetch-stage logic and the IF/ID pipeline register of the pipelined MIPS core.

## Interface

- DATA_W, 16, instruction word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- NOP_WORD, 0, value driven on instr when no valid instruction is held
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ld_start  in  1  reset loader pointer to 0 (no write this cycle)
- ld_en  in  1  write ld_data at loader pointer, then pointer+1
- ld_data  in  DATA_W  word to load
- ld_ptr  out  ADDR_W  current loader pointer
- ld_done  out  1  one-cycle pulse when a write lands at address DEPTH-1
- rd_en  in  1  fetch request
- rd_addr  in  ADDR_W  fetch address (word address)
- stall  in  1  hold current fetch output
- flush  in  1  discard current/incoming fetch
- instr  out  DATA_W  fetched instruction (registered)
- instr_addr  out  ADDR_W  address of instr
- instr_valid  out  1  instr is a valid fetched word

## Operation

- Storage: DEPTH x DATA_W array. Contents not affected by rst; undefined until written.
- Loader: pointer ld_ptr. Per cycle, priority rst > ld_start > ld_en.
  - rst or ld_start: ld_ptr <= 0, no write, ld_done <= 0.
  - ld_en: mem[ld_ptr] <= ld_data; ld_ptr <= ld_ptr+1 (wraps DEPTH-1 -> 0); ld_done <= (ld_ptr == DEPTH-1).
  - Otherwise ld_ptr holds, ld_done <= 0.
- Fetch register (instr, instr_addr, instr_valid), priority rst > flush > stall > rd_en:
  - rst: instr <= NOP_WORD, instr_addr <= 0, instr_valid <= 0.
  - flush: instr <= NOP_WORD, instr_valid <= 0, instr_addr unchanged. Flush overrides stall and rd_en.
  - stall: all three hold, including a held valid word even if its address is rewritten by the loader.
  - rd_en: instr <= word at rd_addr, instr_addr <= rd_addr, instr_valid <= 1.
  - none: instr <= NOP_WORD, instr_valid <= 0, instr_addr holds.
- Read-during-write, same cycle, rd_addr == ld_ptr with ld_en: write-first; instr gets ld_data.
- Addresses exactly span DEPTH; no out-of-range case.

## Timing

- Reset values: instr = NOP_WORD, instr_addr = 0, instr_valid = 0, ld_ptr = 0, ld_done = 0.
- Fetch latency 1 cycle: rd_en/rd_addr sampled at edge N, instr valid after edge N.
- Load latency 1 cycle: word written at edge N is readable by a fetch sampled at edge N (bypass) or later.
- Back-to-back fetches every cycle sustained; throughput 1 word/cycle.
- Stall is level-sensitive; output frozen for every cycle stall is high.
- ld_done high for exactly the cycle after the edge that wrote DEPTH-1.
- rst mid-load: pointer returns to 0; already-written words kept.

## Test plan

- Reset: assert rst 2 cycles with rd_en=1 -> instr=NOP_WORD, instr_valid=0, ld_ptr=0, ld_done=0.
- Load/fetch: ld_start, then 16 ld_en writes of 16'h1000+i -> ld_done pulses once on 16th write, ld_ptr wraps to 0; fetch addrs 0..15 back-to-back -> instr=16'h1000+addr one cycle after each request, instr_valid=1 continuously.
- Stall: fetch addr 3 then stall 3 cycles while rd_addr=7 -> instr=16'h1003, instr_addr=3 held 3 cycles; after release next edge shows 16'h1007.
- Flush vs stall: stall=1 and flush=1 same cycle with valid instr held -> instr=NOP_WORD, instr_valid=0 after edge.
- Write-first bypass: ld_ptr=5, ld_en with ld_data=16'hBEEF and rd_en rd_addr=5 same cycle -> instr=16'hBEEF next cycle.
- Reset mid-load: after 6 writes assert rst -> ld_ptr=0; fetch addr 4 returns previously written 16'h1004.
